// File: rtl/prio_encoder_n.sv
// Registered N-to-clog2(N) priority encoder with valid/ready on both sides.
// Round-robin mode (pointer register and mode input) exists only when PRIO_ENC_RR_EN is defined.
module prio_encoder_n #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_code,
    output logic [N-1:0] out_onehot,
    output logic         out_zero
);

    logic         accept;
    logic         rr_sel;
    logic [W-1:0] ptr;
    logic [W-1:0] idx;
    logic         found;
    logic [W-1:0] win_code;
    logic [N-1:0] win_onehot;
    logic         win_zero;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q;

    assign rr_sel = mode;
    assign ptr    = ptr_q;

    // Next search starts just below the last winner; wraps at N-1, not 2^W-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= W'(N - 1);
        end else if (accept && mode && !win_zero) begin
            ptr_q <= (win_code == '0) ? W'(N - 1) : win_code - 1'b1;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign rr_sel      = 1'b0;
    assign ptr         = W'(N - 1);
`endif

    always_comb begin
        win_code   = '0;
        win_onehot = '0;
        found      = 1'b0;
        idx        = '0;
        win_zero   = ~|req;
        if (rr_sel) begin
            // Search order ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
            for (int s = 0; s < int'(N); s++) begin
                idx = W'((int'(ptr) - s + int'(N)) % int'(N));
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    win_code = idx;
                end
            end
        end else begin
            for (int s = int'(N) - 1; s >= 0; s--) begin
                idx = W'(s);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    win_code = idx;
                end
            end
        end
        if (!win_zero) begin
            win_onehot[win_code] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_onehot <= '0;
            out_zero   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_code   <= win_code;
            out_onehot <= win_onehot;
            out_zero   <= win_zero;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_n.sv
// Self-checking bench for prio_encoder_n (N=4): directed literal checks plus a random phase
// compared every cycle against a behavioural model.
module tb_prio_encoder_n;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] req;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic [N-1:0] out_onehot;
    logic         out_zero;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_valid  = 0;
    int m_code   = 0;
    int m_onehot = 0;
    int m_zero   = 0;
    int m_ptr    = N - 1;

    int sweep_code [16] = '{3, 3, 3, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 0, 0};
`ifdef PRIO_ENC_RR_EN
    int rr_code [5] = '{3, 2, 1, 0, 3};
`else
    int rr_code [5] = '{3, 3, 3, 3, 3};
`endif

    prio_encoder_n #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .req        (req),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_code   (out_code),
        .out_onehot (out_onehot),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input int r, input int rr, input int p);
        int w;
        w = 0;
        if (rr != 0) begin
            for (int s = N - 1; s >= 0; s--) begin
                if (((r >> ((p - s + N) % N)) & 1) != 0) w = (p - s + N) % N;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (((r >> k) & 1) != 0) w = k;
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        int g;
        int rr;
        if (rst) begin
            m_valid  = 0;
            m_code   = 0;
            m_onehot = 0;
            m_zero   = 0;
            m_ptr    = N - 1;
        end else if (in_valid && (m_valid == 0 || out_ready)) begin
`ifdef PRIO_ENC_RR_EN
            rr = int'(mode);
`else
            rr = 0;
`endif
            g        = model_winner(int'(req), rr, m_ptr);
            m_valid  = 1;
            m_zero   = (req == '0) ? 1 : 0;
            m_code   = m_zero != 0 ? 0 : g;
            m_onehot = m_zero != 0 ? 0 : (1 << g);
            if (rr != 0 && m_zero == 0) m_ptr = (g == 0) ? N - 1 : g - 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", int'(in_ready), (!rst && (m_valid == 0 || out_ready)) ? 1 : 0);
        check("out_valid", int'(out_valid), m_valid);
        check("out_code", int'(out_code), m_code);
        check("out_onehot", int'(out_onehot), m_onehot);
        check("out_zero", int'(out_zero), m_zero);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("reset_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", int'(in_ready), 1);

        // Fixed-priority sweep 15..0
        in_valid = 1'b1;
        for (int v = 15; v >= 0; v--) begin
            req = 4'(v);
            step();
            check("sweep_code", int'(out_code), sweep_code[15 - v]);
            check("sweep_zero", int'(out_zero), (v == 0) ? 1 : 0);
            check("sweep_valid", int'(out_valid), 1);
        end

        // Backpressure
        req = 4'b0100;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom_range(1, 15));
            step();
            check("bp_code", int'(out_code), 2);
            check("bp_onehot", int'(out_onehot), 4);
            check("bp_in_ready", int'(in_ready), 0);
        end
        req       = 4'b0011;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", int'(in_ready), 1);
        step();
        check("release_valid", int'(out_valid), 1);
        check("release_code", int'(out_code), 1);

        // Reset mid-stream, then mode=1 with all requests
        mode = 1'b1;
        req  = 4'b1111;
        step();
        rst = 1'b1;
        step();
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_code", int'(out_code), 0);
        check("midrst_onehot", int'(out_onehot), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_code", int'(out_code), rr_code[i]);
        end

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            mode      = 1'($urandom_range(0, 1));
            req       = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            step();
        end

        rst = 1'b0;
        in_valid = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
